// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard stall unit: FSM states, the NOP control word and a load-use helper.
package hazard_stall_unit_pkg;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_MDWAIT = 1'b1
  } hz_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic idex_bubble;
    logic ifid_flush;
    logic muldiv_busy;
  } ctrl_t;

  // Control word while the pipeline is held in reset: frozen front end, both stages squashed.
  localparam ctrl_t CTRL_NOP = '{pc_write: 1'b0, ifid_write: 1'b0, idex_bubble: 1'b1,
                                 ifid_flush: 1'b1, muldiv_busy: 1'b0};

  function automatic logic load_use(input logic mem_read, input logic reg_write,
                                    input logic [4:0] dest, input logic [4:0] rs,
                                    input logic [4:0] rt, input logic uses_rt);
    return mem_read & reg_write & (dest != REG_ZERO) &
           ((dest == rs) | (uses_rt & (dest == rt)));
  endfunction

endpackage

// File: rtl/hazard_stall_unit_muldiv_wait_counter.sv
// Mul/div occupancy counter: synchronous clear, load, and non-wrapping decrement with a zero flag.
module muldiv_wait_counter #(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             load,
  input  logic [CNT_W-1:0] load_value,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             zero
);

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush generator for load-use, mul/div occupancy and taken-branch squash.
// Optional StallCycles performance counter enabled by defining HAZARD_PERF_CNT_EN.
module hazard_stall_unit
  import hazard_stall_unit_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = 4,
  parameter int unsigned CNT_W      = 4
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [4:0] IDU_RsReg,
  input  logic [4:0] IDU_RtReg,
  input  logic       IDU_UsesRt,
  input  logic       IDU_MulDivStart,
  input  logic       EXU_MemRead,
  input  logic       EXU_RegWrite,
  input  logic [4:0] EXU_DestinationRegAddress,
  input  logic       EXU_BranchTaken,
  output logic       PC_Write,
  output logic       IFID_Write,
  output logic       IDEX_Bubble,
  output logic       IFID_Flush,
  output logic       MulDivBusy
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0] StallCycles
`endif
);

  hz_state_t        state, state_next;
  ctrl_t            ctrl;
  logic             lu;
  logic             cnt_load, cnt_dec, cnt_clear;
  logic [CNT_W-1:0] count;
  logic             cnt_zero;
  logic             wait_last;

  assign lu = load_use(EXU_MemRead, EXU_RegWrite, EXU_DestinationRegAddress,
                       IDU_RsReg, IDU_RtReg, IDU_UsesRt);

  muldiv_wait_counter #(.CNT_W(CNT_W)) u_wait_cnt (
    .clk        (Clk),
    .rst_n      (Rst_n),
    .clear      (cnt_clear),
    .load       (cnt_load),
    .load_value (CNT_W'(MULDIV_LAT - 1)),
    .dec        (cnt_dec),
    .count      (count),
    .zero       (cnt_zero)
  );

  // Leave MDWAIT on the cycle the counter steps to zero, giving MULDIV_LAT-1 stall cycles.
  assign wait_last = cnt_zero | (count == CNT_W'(1));

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state <= ST_RUN;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    ctrl       = '{pc_write: 1'b1, ifid_write: 1'b1, default: 1'b0};
    state_next = state;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    cnt_clear  = 1'b0;
    if (EXU_BranchTaken) begin
      ctrl.idex_bubble = 1'b1;
      ctrl.ifid_flush  = 1'b1;
      state_next       = ST_RUN;
      cnt_clear        = 1'b1;
    end else if (state == ST_MDWAIT) begin
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.idex_bubble = 1'b1;
      cnt_dec          = 1'b1;
      if (wait_last) begin
        state_next = ST_RUN;
      end
    end else if (lu) begin
      ctrl.pc_write    = 1'b0;
      ctrl.ifid_write  = 1'b0;
      ctrl.idex_bubble = 1'b1;
    end else if (IDU_MulDivStart) begin
      state_next = ST_MDWAIT;
      cnt_load   = 1'b1;
    end
    ctrl.muldiv_busy = (state == ST_MDWAIT);
    if (!Rst_n) begin
      ctrl = CTRL_NOP;
    end
  end

  assign PC_Write    = ctrl.pc_write;
  assign IFID_Write  = ctrl.ifid_write;
  assign IDEX_Bubble = ctrl.idex_bubble;
  assign IFID_Flush  = ctrl.ifid_flush;
  assign MulDivBusy  = ctrl.muldiv_busy;

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      StallCycles <= '0;
    end else if (!ctrl.pc_write && (StallCycles != '1)) begin
      StallCycles <= StallCycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Self-checking bench for hazard_stall_unit: directed vector table, perf sequence, randomized model check.
module tb_hazard_stall_unit;

  localparam int unsigned LAT = 4;

  typedef struct {
    logic       rst_n;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       ut;
    logic       mds;
    logic       mr;
    logic       rw;
    logic [4:0] dst;
    logic       br;
    logic [4:0] exp; // {pc_write, ifid_write, idex_bubble, ifid_flush, muldiv_busy}
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [4:0] rs, rt, dst;
  logic       ut, mds, mr, rw, br;
  logic       pcw, ifw, bub, flush, busy;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
`endif

  int checks = 0;
  int failures = 0;
  logic [31:0] perf_model = '0;
  logic        perf_valid = 1'b0;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MULDIV_LAT(LAT), .CNT_W(4)) dut (
    .Clk                       (clk),
    .Rst_n                     (rst_n),
    .IDU_RsReg                 (rs),
    .IDU_RtReg                 (rt),
    .IDU_UsesRt                (ut),
    .IDU_MulDivStart           (mds),
    .EXU_MemRead               (mr),
    .EXU_RegWrite              (rw),
    .EXU_DestinationRegAddress (dst),
    .EXU_BranchTaken           (br),
    .PC_Write                  (pcw),
    .IFID_Write                (ifw),
    .IDEX_Bubble               (bub),
    .IFID_Flush                (flush),
    .MulDivBusy                (busy)
`ifdef HAZARD_PERF_CNT_EN
    ,
    .StallCycles               (stall_cycles)
`endif
  );

  function automatic vec_t mk(input logic r, input logic [4:0] a, input logic [4:0] b,
                              input logic u, input logic m, input logic ld, input logic w,
                              input logic [4:0] d, input logic t, input logic [4:0] e);
    vec_t v;
    v.rst_n = r; v.rs = a; v.rt = b; v.ut = u; v.mds = m;
    v.mr = ld; v.rw = w; v.dst = d; v.br = t; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance past the clock edge.
  task automatic step(input vec_t v, input string tag);
    rst_n = v.rst_n; rs = v.rs; rt = v.rt; ut = v.ut; mds = v.mds;
    mr = v.mr; rw = v.rw; dst = v.dst; br = v.br;
    @(negedge clk);
    chk({tag, ".ctrl"}, {27'd0, pcw, ifw, bub, flush, busy}, {27'd0, v.exp});
`ifdef HAZARD_PERF_CNT_EN
    if (perf_valid) chk({tag, ".perf"}, stall_cycles, perf_model);
`endif
    @(posedge clk);
    if (!v.rst_n) begin
      perf_model = '0;
      perf_valid = 1'b1;
    end else if (!v.exp[4] && perf_model != 32'hFFFF_FFFF) begin
      perf_model = perf_model + 32'd1;
    end
    #1;
  endtask

  vec_t tbl[21];
  vec_t v;
  int   stall_left;
  logic lu;

  initial begin
    // rst rs  rt  ut mds mr rw dst br  {pcw,ifw,bub,flush,busy}
    tbl[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110);  // reset forces NOP control
    tbl[1]  = mk(1, 8, 1, 1, 0, 1, 1, 8, 0, 5'b00100);  // lw $t0 -> add rs=8: stall
    tbl[2]  = mk(1, 8, 1, 1, 0, 0, 0, 0, 0, 5'b11000);  // bubble in EX: clear
    tbl[3]  = mk(1, 0, 0, 1, 0, 1, 1, 0, 0, 5'b11000);  // $0 never stalls
    tbl[4]  = mk(1, 3, 9, 0, 0, 1, 1, 9, 0, 5'b11000);  // rt match but rt unused
    tbl[5]  = mk(1, 3, 9, 1, 0, 1, 1, 9, 0, 5'b00100);  // rt used: stall
    tbl[6]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11000);  // mul/div advances
    tbl[7]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00101);
    tbl[8]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00101);
    tbl[9]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00101);
    tbl[10] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);  // back to RUN after 3 stalls
    tbl[11] = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11000);
    tbl[12] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00101);  // count=3
    tbl[13] = mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 5'b11111);  // count=2, branch aborts
    tbl[14] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    tbl[15] = mk(1, 8, 0, 0, 1, 1, 1, 8, 0, 5'b00100);  // LU beats mul/div start
    tbl[16] = mk(1, 8, 0, 0, 1, 0, 0, 0, 0, 5'b11000);  // mul/div re-seen, enters wait
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110);  // reset during MDWAIT
    tbl[18] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);
    tbl[19] = mk(1, 5, 0, 0, 0, 1, 1, 5, 1, 5'b11110);  // branch with LU: flush only
    tbl[20] = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000);

    for (int i = 0; i < 21; i++) step(tbl[i], $sformatf("vec%0d", i));

    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110), "perf.rst");
    step(mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 5'b11000), "perf.md");
    for (int i = 0; i < 3; i++) step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00101), "perf.wait");
    step(mk(1, 7, 0, 0, 0, 1, 1, 7, 0, 5'b00100), "perf.lu");
    step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 5'b11000), "perf.idle");
`ifdef HAZARD_PERF_CNT_EN
    chk("perf.total", stall_cycles, 32'd4);
`endif

    step(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 5'b00110), "rand.rst");
    stall_left = 0;
    for (int n = 0; n < 400; n++) begin
      v.rst_n = ($urandom_range(0, 39) != 0);
      v.rs    = 5'($urandom_range(0, 3));
      v.rt    = 5'($urandom_range(0, 3));
      v.ut    = 1'($urandom_range(0, 1));
      v.mds   = ($urandom_range(0, 5) == 0);
      v.mr    = 1'($urandom_range(0, 1));
      v.rw    = ($urandom_range(0, 3) != 0);
      v.dst   = 5'($urandom_range(0, 3));
      v.br    = ($urandom_range(0, 7) == 0);
      lu = v.mr && v.rw && v.dst != 0 && (v.dst == v.rs || (v.ut && v.dst == v.rt));
      if (!v.rst_n)             v.exp = 5'b00110;
      else if (v.br)            v.exp = {4'b1111, stall_left > 0};
      else if (stall_left > 0)  v.exp = 5'b00101;
      else if (lu)              v.exp = 5'b00100;
      else                      v.exp = 5'b11000;
      step(v, $sformatf("rand%0d", n));
      if (!v.rst_n || v.br)    stall_left = 0;
      else if (stall_left > 0) stall_left--;
      else if (!lu && v.mds)   stall_left = LAT - 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
